// File: rtl/prog_loader_pkg.sv
// Shared types and framing constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of prog_loader.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rearm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  modport master (
    input  rx_valid, rx_data, rearm,
    output imem_we, imem_addr, imem_wdata, core_rst, done, error
  );

  modport slave (
    output rx_valid, rx_data, rearm,
    input  imem_we, imem_addr, imem_wdata, core_rst, done, error
  );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_ready_o pulses the
// cycle after the last byte of a word is sampled.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;
  logic [31:0] word_q, word_d;
  logic        rdy_q, rdy_d;

  assign last_byte_o  = byte_valid_i && (idx_q == 2'(WORD_BYTES - 1));
  assign word_ready_o = rdy_q;
  assign word_o       = word_q;

  always_comb begin
    idx_d  = idx_q;
    sh_d   = sh_q;
    word_d = word_q;
    rdy_d  = 1'b0;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      if (last_byte_o) begin
        word_d = {byte_i, sh_q};
        rdy_d  = 1'b1;
        idx_d  = '0;
      end else begin
        case (idx_q)
          2'd0:    sh_d[7:0]   = byte_i;
          2'd1:    sh_d[15:8]  = byte_i;
          default: sh_d[23:16] = byte_i;
        endcase
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      rdy_q  <= rdy_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream into imem
// writes and holds the core in reset until a verified image is present.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  prog_loader_if.master  bus
);

  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [1:0]          hidx_q, hidx_d;
  logic [23:0]         hdr_q, hdr_d;
  logic [ADDR_W:0]     nwords_q, nwords_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic [31:0]         tmo_q, tmo_d;

  logic        in_load, tmo_hit;
  logic        last_byte, word_ready;
  logic [31:0] word;
  logic [31:0] n_full;

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != ST_DATA),
    .byte_valid_i (bus.rx_valid && (state_q == ST_DATA)),
    .byte_i       (bus.rx_data),
    .last_byte_o  (last_byte),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  assign in_load = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign tmo_hit = in_load && !bus.rx_valid && (tmo_q == 32'(TIMEOUT_CYC - 1));
  assign n_full  = {bus.rx_data, hdr_q};

  always_comb begin
    state_d  = state_q;
    hidx_d   = hidx_q;
    hdr_d    = hdr_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    tmo_d    = '0;

    if (in_load) tmo_d = bus.rx_valid ? 32'd0 : tmo_q + 32'd1;
    // Address advances after the write is presented, so imem_addr is valid with imem_we.
    if (word_ready) addr_d = addr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          hdr_d[7:0] = bus.rx_data;
          hidx_d     = 2'd1;
          csum_d     = '0;
          wcnt_d     = '0;
          addr_d     = '0;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (bus.rx_valid) begin
          if (hidx_q == 2'(HDR_BYTES - 1)) begin
            hidx_d = '0;
            if ({1'b0, n_full} > CAP) begin
              state_d = ST_ERR;
            end else begin
              nwords_d = n_full[ADDR_W:0];
              state_d  = (n_full == 32'd0) ? ST_CSUM : ST_DATA;
            end
          end else begin
            if (hidx_q == 2'd1) hdr_d[15:8]  = bus.rx_data;
            else                hdr_d[23:16] = bus.rx_data;
            hidx_d = hidx_q + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          csum_d = csum_q + bus.rx_data;
          if (last_byte) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_d == nwords_q) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (bus.rearm) begin
          state_d = ST_IDLE;
          csum_d  = '0;
          wcnt_d  = '0;
          addr_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) state_d = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hidx_q   <= '0;
      hdr_q    <= '0;
      nwords_q <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      hidx_q   <= hidx_d;
      hdr_q    <= hdr_d;
      nwords_q <= nwords_d;
      wcnt_q   <= wcnt_d;
      addr_q   <= addr_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.imem_we    = word_ready;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign bus.core_rst   = (state_q != ST_DONE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected imem writes are queued as bytes
// are issued and checked by a negedge monitor; status is checked inline.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int AW  = 4;
  localparam int TMO = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t exp_q[$];
  int  errors  = 0;
  int  checks  = 0;
  int  wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected none",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_u32(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_payload(input logic [31:0] img[$]);
    send_u32(32'(img.size()));
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back(wr_t'{addr: AW'(i), data: img[i]});
      send_u32(img[i]);
    end
  endtask

  task automatic do_rearm();
    @(negedge clk);
    bus.rearm = 1'b1;
    @(posedge clk);
    #1;
    bus.rearm = 1'b0;
  endtask

  function automatic logic [7:0] csum_of(input logic [31:0] img[$]);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < img.size(); i++)
      for (int k = 0; k < 4; k++) s = s + img[i][8*k +: 8];
    return s;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(bus.imem_we),   32'd0);
    chk({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
    chk({tag, "_wdata"}, bus.imem_wdata,     32'd0);
    chk({tag, "_crst"},  32'(bus.core_rst),  32'd1);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
    chk({tag, "_err"},   32'(bus.error),     32'd0);
  endtask

  initial begin
    logic [31:0] good[$];
    logic [31:0] empty[$];
    logic [7:0]  cs;
    int          w0;

    good  = '{32'h0000_0013, 32'hDEAD_BEEF};
    empty = {};
    cs    = csum_of(good);

    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rearm    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Good image, one byte per cycle
    w0 = wr_seen;
    send_payload(good);
    @(negedge clk);
    chk("good_pre_crst", 32'(bus.core_rst), 32'd1);
    chk("good_pre_done", 32'(bus.done), 32'd0);
    send_byte(cs);
    chk("good_done", 32'(bus.done), 32'd1);
    chk("good_crst", 32'(bus.core_rst), 32'd0);
    chk("good_err", 32'(bus.error), 32'd0);
    chk("good_nwr", 32'(wr_seen - w0), 32'd2);

    // Bad checksum, then rearm and resend
    do_rearm();
    chk("rearm_done", 32'(bus.done), 32'd0);
    chk("rearm_crst", 32'(bus.core_rst), 32'd1);
    send_payload(good);
    send_byte(8'h00);
    chk("badcs_err", 32'(bus.error), 32'd1);
    chk("badcs_done", 32'(bus.done), 32'd0);
    chk("badcs_crst", 32'(bus.core_rst), 32'd1);
    send_byte(cs);
    chk("err_ignores_rx", 32'(bus.error), 32'd1);
    do_rearm();
    chk("rearm_err", 32'(bus.error), 32'd0);
    send_payload(good);
    send_byte(cs);
    chk("resend_done", 32'(bus.done), 32'd1);

    // Rearm with a simultaneous byte: byte must be dropped
    @(negedge clk);
    bus.rearm    = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h00;
    @(posedge clk);
    #1;
    bus.rearm    = 1'b0;
    bus.rx_valid = 1'b0;
    w0 = wr_seen;
    send_payload(empty);
    chk("n0_hdr_done", 32'(bus.done), 32'd0);
    send_byte(8'h00);
    chk("n0_done", 32'(bus.done), 32'd1);
    chk("n0_nwr", 32'(wr_seen - w0), 32'd0);

    // Oversized header
    do_rearm();
    w0 = wr_seen;
    for (int k = 0; k < 3; k++) send_byte(k == 0 ? 8'(2**AW + 1) : 8'h00);
    chk("ovf_pre_err", 32'(bus.error), 32'd0);
    send_byte(8'h00);
    chk("ovf_err", 32'(bus.error), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovf_nwr", 32'(wr_seen - w0), 32'd0);

    // Stall after 5 payload bytes
    do_rearm();
    send_u32(32'd2);
    exp_q.push_back(wr_t'{addr: '0, data: 32'hCAFE_0001});
    send_u32(32'hCAFE_0001);
    send_byte(8'h77);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_pre_err", 32'(bus.error), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("tmo_err", 32'(bus.error), 32'd1);

    // Reset mid-DATA, then full resend
    do_rearm();
    send_u32(32'd2);
    exp_q.push_back(wr_t'{addr: '0, data: 32'h1234_5678});
    send_u32(32'h1234_5678);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    send_payload(good);
    send_byte(cs);
    chk("postrst_done", 32'(bus.done), 32'd1);
    chk("postrst_crst", 32'(bus.core_rst), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
